uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Purpose: receive-side controller for a UART. It buffers good bytes in a
//          show-ahead FIFO, counts frame and parity errors, flags overrun and
//          (optionally) an idle timeout, and raises a registered interrupt.
// Latency: an accepted byte is visible on rd_valid_o/level_o one cycle after
//          its pulse. irq_o lags level/overrun/timeout by one further cycle.
// Backpressure: there is none toward the receiver. A byte arriving while the
//          FIFO is full, with no pop in the same cycle, is dropped and sets
//          the sticky overrun_o flag.
// Ports:  clk_i, reset_ni (async, active-low); rx_data_i/rx_valid_i/
//         rx_frame_err_i/rx_parity_err_i from the receiver; rd_en_i/clear_i
//         from the host; rd_data_o/rd_valid_o/level_o FIFO head and
//         occupancy; overrun_o, frame_err_cnt_o, parity_err_cnt_o,
//         timeout_o, irq_o status.
// Config: define UART_RX_CTRL_TIMEOUT_EN to build the idle-timeout FSM.
//         Without it, timeout_o is tied to 0.
module uart_rx_ctrl #(
  parameter int FifoDepth     = 16,
  parameter int IrqThreshold  = 8,
  parameter int TimeoutCycles = 1000
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_valid_i,
  input  logic                         rx_frame_err_i,
  input  logic                         rx_parity_err_i,
  input  logic                         rd_en_i,
  input  logic                         clear_i,
  output logic [7:0]                   rd_data_o,
  output logic                         rd_valid_o,
  output logic [$clog2(FifoDepth):0]   level_o,
  output logic                         overrun_o,
  output logic [7:0]                   frame_err_cnt_o,
  output logic [7:0]                   parity_err_cnt_o,
  output logic                         timeout_o,
  output logic                         irq_o
);

  localparam int AW = $clog2(FifoDepth);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FullLvl = LW'(FifoDepth);
  localparam logic [LW-1:0] IrqLvl  = LW'(IrqThreshold);

  logic [7:0]    mem_q [FifoDepth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]    parity_cnt_q, parity_cnt_d;
  logic          irq_q, irq_d;
  logic          push_req, push, pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overrun_d    = overrun_q;
    frame_cnt_d  = frame_cnt_q;
    parity_cnt_d = parity_cnt_q;

    // Any error qualifier poisons the byte. clear_i masks everything.
    push_req = rx_valid_i & ~rx_frame_err_i & ~rx_parity_err_i & ~clear_i;
    pop      = rd_en_i & (level_q != '0) & ~clear_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push     = push_req & ((level_q != FullLvl) | pop);

    if (clear_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      overrun_d    = 1'b0;
      frame_cnt_d  = '0;
      parity_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (push_req && !push) overrun_d = 1'b1;
      if (rx_frame_err_i && frame_cnt_q != 8'hFF)   frame_cnt_d  = frame_cnt_q + 8'd1;
      if (rx_parity_err_i && parity_cnt_q != 8'hFF) parity_cnt_d = parity_cnt_q + 8'd1;
    end

    // Built from the registered status, so irq_o trails it by one cycle.
    irq_d = (level_q >= IrqLvl) | overrun_q | timeout_o;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
      parity_cnt_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
      parity_cnt_q <= parity_cnt_d;
      irq_q        <= irq_d;
    end
  end

  // Storage needs no reset. Its contents are ignored while rd_valid_o is 0.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rx_data_i;
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TIMEOUT} tmo_state_e;

  tmo_state_e    state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    if (clear_i || (pop && !push && level_q == LW'(1))) begin
      state_d    = ST_IDLE;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (push) begin
            state_d    = ST_WAIT;
            idle_cnt_d = '0;
          end
        end
        ST_WAIT: begin
          if (push) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == CW'(TimeoutCycles - 1)) begin
            state_d    = ST_TIMEOUT;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
        ST_TIMEOUT: begin
          if (push) begin
            state_d    = ST_WAIT;
            idle_cnt_d = '0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign timeout_o = (state_q == ST_TIMEOUT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles >= 2);
  assign timeout_o = 1'b0;
`endif

  assign rd_data_o        = mem_q[rd_ptr_q];
  assign rd_valid_o       = (level_q != '0);
  assign level_o          = level_q;
  assign overrun_o        = overrun_q;
  assign frame_err_cnt_o  = frame_cnt_q;
  assign parity_err_cnt_o = parity_cnt_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic [7:0] rx_data_i;
  logic       rx_valid_i, rx_frame_err_i, rx_parity_err_i, rd_en_i, clear_i;
  logic [7:0] rd_data_o, frame_err_cnt_o, parity_err_cnt_o;
  logic       rd_valid_o, overrun_o, timeout_o, irq_o;
  logic [4:0] level_o;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(.FifoDepth(16), .IrqThreshold(8), .TimeoutCycles(10)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .rx_frame_err_i(rx_frame_err_i),
    .rx_parity_err_i(rx_parity_err_i), .rd_en_i(rd_en_i), .clear_i(clear_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .level_o(level_o),
    .overrun_o(overrun_o), .frame_err_cnt_o(frame_err_cnt_o),
    .parity_err_cnt_o(parity_err_cnt_o), .timeout_o(timeout_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge. Inputs set after this
  // are sampled on the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    cyc();
    rx_valid_i = 1'b0;
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    cyc();
    rd_en_i = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0; rx_frame_err_i = 1'b0;
    rx_parity_err_i = 1'b0; rd_en_i = 1'b0; clear_i = 1'b0;
    repeat (3) cyc();
    check("rst_level", level_o, 0);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_frame_cnt", frame_err_cnt_o, 0);
    check("rst_parity_cnt", parity_err_cnt_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_irq", irq_o, 0);
    #2 reset_ni = 1'b1;
    cyc();

    // Three bytes in, three out, in order.
    push(8'h41);
    check("p1_level", level_o, 1);
    check("p1_rd_valid", rd_valid_o, 1);
    push(8'h42);
    push(8'h43);
    check("p3_level", level_o, 3);
    check("p3_irq_below_thr", irq_o, 0);
    check("head_41", rd_data_o, 8'h41);
    pop();
    check("head_42", rd_data_o, 8'h42);
    check("pop1_level", level_o, 2);
    pop();
    check("head_43", rd_data_o, 8'h43);
    pop();
    check("pop3_level", level_o, 0);
    check("pop3_rd_valid", rd_valid_o, 0);

    // A pop on an empty FIFO changes nothing.
    pop();
    check("empty_pop_level", level_o, 0);
    check("empty_pop_rd_valid", rd_valid_o, 0);

    // Error pulses: discard the byte, count and saturate.
    rx_data_i = 8'h55; rx_valid_i = 1'b1; rx_frame_err_i = 1'b1;
    cyc();
    check("ferr_discard_level", level_o, 0);
    check("ferr_cnt_1", frame_err_cnt_o, 1);
    rx_valid_i = 1'b0; rx_parity_err_i = 1'b1;
    cyc();
    check("both_ferr_cnt", frame_err_cnt_o, 2);
    check("both_perr_cnt", parity_err_cnt_o, 1);
    rx_parity_err_i = 1'b0;
    repeat (298) cyc();
    rx_frame_err_i = 1'b0;
    rx_valid_i = 1'b1; rx_parity_err_i = 1'b1;
    cyc();
    rx_valid_i = 1'b0; rx_parity_err_i = 1'b0;
    check("ferr_sat_255", frame_err_cnt_o, 255);
    check("perr_cnt_2", parity_err_cnt_o, 2);
    check("err_level_0", level_o, 0);
    clear_i = 1'b1; rx_valid_i = 1'b1; rx_frame_err_i = 1'b1;
    cyc();
    clear_i = 1'b0; rx_valid_i = 1'b0; rx_frame_err_i = 1'b0;
    check("clr_ferr_cnt", frame_err_cnt_o, 0);
    check("clr_perr_cnt", parity_err_cnt_o, 0);
    check("clr_push_ignored", level_o, 0);

    // 17 bytes into a 16-deep FIFO: the last is dropped and overrun is set.
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    check("fill16_level", level_o, 16);
    check("fill16_overrun", overrun_o, 0);
    push(8'hEE);
    check("p17_level", level_o, 16);
    check("p17_overrun", overrun_o, 1);
    check("p17_irq", irq_o, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovr_head_%0d", i), rd_data_o, 8'h10 + 8'(i));
      pop();
    end
    check("ovr_drain_level", level_o, 0);
    check("ovr_sticky", overrun_o, 1);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check("clr_overrun", overrun_o, 0);

    // Push and pop together at a mid level: the level holds.
    push(8'hA0);
    push(8'hA1);
    rx_data_i = 8'hA2; rx_valid_i = 1'b1; rd_en_i = 1'b1;
    cyc();
    rx_valid_i = 1'b0; rd_en_i = 1'b0;
    check("mid_pp_level", level_o, 2);
    check("mid_pp_head", rd_data_o, 8'hA1);
    pop();
    check("mid_pp_head2", rd_data_o, 8'hA2);
    pop();
    check("mid_pp_empty", level_o, 0);

    // Full FIFO with push and pop together, then an asynchronous reset.
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    rx_data_i = 8'h70; rx_valid_i = 1'b1; rd_en_i = 1'b1;
    cyc();
    rx_valid_i = 1'b0; rd_en_i = 1'b0;
    check("full_pp_level", level_o, 16);
    check("full_pp_overrun", overrun_o, 0);
    check("full_pp_head", rd_data_o, 8'h61);
    rx_frame_err_i = 1'b1;
    cyc();
    rx_frame_err_i = 1'b0;
    check("pre_rst_ferr", frame_err_cnt_o, 1);
    check("pre_rst_irq", irq_o, 1);
    #2 reset_ni = 1'b0;
    #1;
    check("arst_level", level_o, 0);
    check("arst_rd_valid", rd_valid_o, 0);
    check("arst_overrun", overrun_o, 0);
    check("arst_ferr", frame_err_cnt_o, 0);
    check("arst_timeout", timeout_o, 0);
    check("arst_irq", irq_o, 0);
    cyc();
    #2 reset_ni = 1'b1;
    cyc();

`ifdef UART_RX_CTRL_TIMEOUT_EN
    // One byte, then idle: timeout after 10 cycles, irq one cycle later.
    push(8'h99);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check($sformatf("tmo_wait_%0d", k), timeout_o, 0);
    end
    cyc();
    check("tmo_set", timeout_o, 1);
    check("tmo_irq_lag", irq_o, 0);
    cyc();
    check("tmo_irq", irq_o, 1);
    pop();
    check("tmo_pop_clear", timeout_o, 0);
    check("tmo_pop_level", level_o, 0);
    cyc();
    check("tmo_pop_irq", irq_o, 0);
`else
    // Without the timeout feature, pending data never times out.
    push(8'h99);
    repeat (15) cyc();
    check("no_tmo_timeout", timeout_o, 0);
    check("no_tmo_irq", irq_o, 0);
    pop();
    check("no_tmo_level", level_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
